// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// width helper for the shared hold/stagger down-counter.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HOLD = 2'd1,
        S_REL  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    // clog2(max(hold, stagger)), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned stagger);
        int unsigned m;
        m = (hold > stagger) ? hold : stagger;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software request and per-channel reset bundle between the sequencer and its users.
interface reset_sequencer_if #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned CNT_W = 8
);
    logic             sw_req;
    logic [N_CH-1:0]  ch_mask;
    logic [N_CH-1:0]  rst_out;
    logic             ready;
    logic [CNT_W-1:0] seq_count;

    modport master (
        output sw_req, ch_mask,
        input  rst_out, ready, seq_count
    );

    modport slave (
        input  sw_req, ch_mask,
        output rst_out, ready, seq_count
    );
endinterface

// File: rtl/reset_sequencer_rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser, STAGES flops deep.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], 1'b1};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: synchronised release, programmable hold, staggered per-channel
// release in ascending order, and software re-reset of a masked channel subset.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);
    localparam int unsigned   CW        = cnt_width(HOLD_CYCLES, STAGGER);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LOAD = CW'(STAGGER - 1);
    localparam logic [CNT_W-1:0] SEQ_MAX = {CNT_W{1'b1}};

    logic             sync_rst_n;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_CH-1:0]  pend, pend_n;
    logic [N_CH-1:0]  rst_out, rst_out_n;
    logic             ready, ready_n;
    logic [CNT_W-1:0] seq_count, seq_count_n;
    logic [N_CH-1:0]  first_c;
    logic [N_CH-1:0]  rest_c;
    logic             rel_c;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .q     (sync_rst_n)
    );

    // Lowest still-pending active channel; unmasked indices never appear in pend.
    assign first_c = pend & (~pend + N_CH'(1));
    assign rest_c  = pend & ~first_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SYNC;
            cnt       <= HOLD_LOAD;
            pend      <= '1;
            rst_out   <= '1;
            ready     <= 1'b0;
            seq_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend      <= pend_n;
            rst_out   <= rst_out_n;
            ready     <= ready_n;
            seq_count <= seq_count_n;
        end
    end

    // The S_SYNC exit edge is the first hold cycle, so hold length is counted
    // from the first edge that sees the synchronised release.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pend_n      = pend;
        rst_out_n   = rst_out;
        ready_n     = ready;
        seq_count_n = seq_count;
        rel_c       = 1'b0;

        case (state)
            S_SYNC: begin
                if (sync_rst_n) begin
                    if (cnt == '0) begin
                        rel_c = 1'b1;
                    end else begin
                        cnt_n   = cnt - CW'(1);
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD, S_REL: begin
                if (cnt == '0) rel_c = 1'b1;
                else           cnt_n = cnt - CW'(1);
            end
            S_RUN: begin
                if (bus.sw_req && (bus.ch_mask != '0)) begin
                    rst_out_n = rst_out | bus.ch_mask;
                    pend_n    = bus.ch_mask;
                    ready_n   = 1'b0;
                    cnt_n     = HOLD_LOAD;
                    state_n   = S_HOLD;
                end
            end
            default: state_n = S_SYNC;
        endcase

        if (rel_c) begin
            rst_out_n = rst_out & ~first_c;
            pend_n    = rest_c;
            if (rest_c == '0) begin
                state_n = S_RUN;
                ready_n = 1'b1;
                if (seq_count != SEQ_MAX) seq_count_n = seq_count + CNT_W'(1);
            end else begin
                state_n = S_REL;
                cnt_n   = STAG_LOAD;
            end
        end
    end

    assign bus.rst_out   = rst_out;
    assign bus.ready     = ready;
    assign bus.seq_count = seq_count;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default, saturating (CNT_W=2) and swept (N_CH=5) sequencers
// sharing one clock and board reset.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reset_sequencer_if #(.N_CH(3), .CNT_W(8)) bus_a ();
    reset_sequencer_if #(.N_CH(3), .CNT_W(2)) bus_s ();
    reset_sequencer_if #(.N_CH(5), .CNT_W(8)) bus_p ();

    reset_sequencer #(.N_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    reset_sequencer #(.N_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s.slave)
    );
    reset_sequencer #(.N_CH(5), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER(1), .CNT_W(8)) dut_p (
        .clk(clk), .reset(reset), .bus(bus_p.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sw_a(input logic [2:0] mask);
        bus_a.sw_req  = 1'b1;
        bus_a.ch_mask = mask;
        step();
        bus_a.sw_req  = 1'b0;
        bus_a.ch_mask = 3'b000;
    endtask

    // Full hardware sequence starting from edge 1 on all three instances.
    task automatic run_hw_seq(input string tag);
        logic [2:0] exp_a;
        logic [4:0] exp_p;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp_a = (e < 6) ? 3'b111 : (e < 8) ? 3'b110 : (e < 10) ? 3'b100 : 3'b000;
            check($sformatf("%s_a_rst_e%0d", tag, e), 32'(bus_a.rst_out), 32'(exp_a));
            exp_p = '0;
            for (int i = 0; i < 5; i++) exp_p[i] = (e < 4 + i);
            check($sformatf("%s_p_rst_e%0d", tag, e), 32'(bus_p.rst_out), 32'(exp_p));
            if (e == 7) check({tag, "_p_ready_e7"}, 32'(bus_p.ready), 32'd0);
            if (e == 8) begin
                check({tag, "_p_ready_e8"}, 32'(bus_p.ready), 32'd1);
                check({tag, "_p_seq_e8"}, 32'(bus_p.seq_count), 32'd1);
            end
            if (e == 9) begin
                check({tag, "_a_ready_e9"}, 32'(bus_a.ready), 32'd0);
                check({tag, "_a_seq_e9"}, 32'(bus_a.seq_count), 32'd0);
            end
            if (e == 10) begin
                check({tag, "_a_ready_e10"}, 32'(bus_a.ready), 32'd1);
                check({tag, "_a_seq_e10"}, 32'(bus_a.seq_count), 32'd1);
                check({tag, "_s_rst_e10"}, 32'(bus_s.rst_out), 32'd0);
                check({tag, "_s_seq_e10"}, 32'(bus_s.seq_count), 32'd1);
            end
        end
    endtask

    initial begin
        logic [2:0] exp3;
        int         exp_seq;

        reset         = 1'b0;
        bus_a.sw_req  = 1'b0; bus_a.ch_mask = '0;
        bus_s.sw_req  = 1'b0; bus_s.ch_mask = '0;
        bus_p.sw_req  = 1'b0; bus_p.ch_mask = '0;

        // Power-on reset values
        repeat (3) @(negedge clk);
        check("por_a_rst", 32'(bus_a.rst_out), 32'h7);
        check("por_a_ready", 32'(bus_a.ready), 32'd0);
        check("por_a_seq", 32'(bus_a.seq_count), 32'd0);
        check("por_p_rst", 32'(bus_p.rst_out), 32'h1f);
        reset = 1'b1;
        run_hw_seq("hw1");

        // Software partial reset of channels 0 and 2
        sw_a(3'b101);
        check("sw101_k_rst", 32'(bus_a.rst_out), 32'h5);
        check("sw101_k_ready", 32'(bus_a.ready), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            exp3 = (j < 4) ? 3'b101 : (j < 6) ? 3'b100 : 3'b000;
            check($sformatf("sw101_k%0d_rst", j), 32'(bus_a.rst_out), 32'(exp3));
        end
        check("sw101_ready", 32'(bus_a.ready), 32'd1);
        check("sw101_seq", 32'(bus_a.seq_count), 32'd2);

        // Empty mask is ignored in S_RUN
        sw_a(3'b000);
        check("mask0_rst", 32'(bus_a.rst_out), 32'h0);
        check("mask0_ready", 32'(bus_a.ready), 32'd1);
        step();
        check("mask0_seq", 32'(bus_a.seq_count), 32'd2);

        // Request during S_REL is ignored
        sw_a(3'b011);
        check("sw011_k_rst", 32'(bus_a.rst_out), 32'h3);
        repeat (4) step();
        check("sw011_k4_rst", 32'(bus_a.rst_out), 32'h2);
        sw_a(3'b111);
        check("inrel_k5_rst", 32'(bus_a.rst_out), 32'h2);
        check("inrel_k5_ready", 32'(bus_a.ready), 32'd0);
        step();
        check("inrel_k6_rst", 32'(bus_a.rst_out), 32'h0);
        check("inrel_k6_ready", 32'(bus_a.ready), 32'd1);
        check("inrel_k6_seq", 32'(bus_a.seq_count), 32'd3);

        // Saturating counter with CNT_W=2
        for (int n = 1; n <= 5; n++) begin
            bus_s.sw_req  = 1'b1;
            bus_s.ch_mask = 3'b001;
            step();
            bus_s.sw_req  = 1'b0;
            bus_s.ch_mask = 3'b000;
            check($sformatf("sat%0d_k_rst", n), 32'(bus_s.rst_out), 32'h1);
            repeat (4) step();
            check($sformatf("sat%0d_rst", n), 32'(bus_s.rst_out), 32'h0);
            exp_seq = (1 + n > 3) ? 3 : 1 + n;
            check($sformatf("sat%0d_seq", n), 32'(bus_s.seq_count), 32'(exp_seq));
        end

        // Sub-cycle reset pulse while dut_a is in S_REL with ch0 released
        sw_a(3'b111);
        repeat (4) step();
        check("mid_k4_rst", 32'(bus_a.rst_out), 32'h6);
        step();
        #2 reset = 1'b0;
        #1;
        check("mid_a_rst", 32'(bus_a.rst_out), 32'h7);
        check("mid_a_ready", 32'(bus_a.ready), 32'd0);
        check("mid_a_seq", 32'(bus_a.seq_count), 32'd0);
        check("mid_s_seq", 32'(bus_s.seq_count), 32'd0);
        check("mid_p_rst", 32'(bus_p.rst_out), 32'h1f);
        check("mid_p_ready", 32'(bus_p.ready), 32'd0);
        #1 reset = 1'b1;
        run_hw_seq("hw2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
